// File: rtl/frag_out_buf.sv
// frag_out_buf -- fragment output buffer between the sample test and the z-buffer.
// A DEPTH-entry FIFO holding a signed hit position plus its colour.
// Optional statistics counters are enabled by defining FRAG_BUF_STATS_EN.
//
// Handshakes:
//   Upstream:   a fragment is pushed on a rising edge when hit_valid_R18H=1 and
//               halt_R18L=1. halt_R18L=0 means the upstream stage must hold its
//               fragment. halt_R18L depends only on registered occupancy.
//   Downstream: the head entry is popped on a rising edge when frag_valid_R19H=1
//               and frag_ready_R19H=1. The head stays stable while it is valid
//               and not popped.
module frag_out_buf #(
  parameter int SIGFIG = 24,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [SIGFIG*AXIS-1:0]    hit_R18S,
  input  logic        [SIGFIG*COLORS-1:0]  color_R18U,
  input  logic                             hit_valid_R18H,
  output logic                             halt_R18L,
  output logic signed [SIGFIG*AXIS-1:0]    frag_R19S,
  output logic        [SIGFIG*COLORS-1:0]  color_R19U,
  output logic                             frag_valid_R19H,
  input  logic                             frag_ready_R19H,
  output logic        [$clog2(DEPTH):0]    count_R19U
`ifdef FRAG_BUF_STATS_EN
  ,
  output logic        [31:0]               hit_total_R19U,
  output logic        [31:0]               stall_cyc_R19U
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = SIGFIG * AXIS;
  localparam int KW = SIGFIG * COLORS;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [HW-1:0] hit_mem   [DEPTH];
  logic [KW-1:0] color_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Flags come straight from the occupancy register, so there is no path
  // from frag_ready_R19H back to halt_R18L.
  assign halt_R18L       = (count_R19U != FULL_CNT);
  assign frag_valid_R19H = (count_R19U != '0);

  assign push = hit_valid_R18H & halt_R18L;
  assign pop  = frag_valid_R19H & frag_ready_R19H;

  // Head entry is read directly from storage; zero while the buffer is empty.
  assign frag_R19S  = frag_valid_R19H ? hit_mem[rd_ptr]   : '0;
  assign color_R19U = frag_valid_R19H ? color_mem[rd_ptr] : '0;

  // Storage write; contents are never cleared, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      hit_mem[wr_ptr]   <= hit_R18S;
      color_mem[wr_ptr] <= color_R18U;
    end
  end

  // Pointers wrap modulo DEPTH; count disambiguates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_R19U <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_R19U <= count_R19U + CW'(1);
        2'b01:   count_R19U <= count_R19U - CW'(1);
        default: count_R19U <= count_R19U;
      endcase
    end
  end

`ifdef FRAG_BUF_STATS_EN
  // Accepted-push and upstream-stall counters, both wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_total_R19U <= '0;
      stall_cyc_R19U <= '0;
    end else begin
      if (push)                         hit_total_R19U <= hit_total_R19U + 32'd1;
      if (hit_valid_R18H && !halt_R18L) stall_cyc_R19U <= stall_cyc_R19U + 32'd1;
    end
  end
`endif

endmodule

// File: doc/frag_out_buf.md
FRAG_OUT_BUF -- requirements
Module: frag_out_buf

Interface
REQ-001 Parameter SIGFIG, default 24, bits per coordinate/colour word.
REQ-002 Parameter AXIS, default 3, coordinates per fragment (x,y,z).
REQ-003 Parameter COLORS, default 3, colour channels per fragment.
REQ-004 Parameter DEPTH, default 4, FIFO entries; power of two, >=2.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 hit_R18S  input  SIGFIG x AXIS  signed hit fragment from sample test.
REQ-008 color_R18U  input  SIGFIG x COLORS  unsigned fragment colour.
REQ-009 hit_valid_R18H  input  1  fragment valid this cycle.
REQ-010 halt_R18L  output  1  active-low halt; 1 = buffer accepts, 0 = upstream must hold.
REQ-011 frag_R19S  output  SIGFIG x AXIS  head-of-FIFO fragment.
REQ-012 color_R19U  output  SIGFIG x COLORS  head-of-FIFO colour.
REQ-013 frag_valid_R19H  output  1  head entry valid.
REQ-014 frag_ready_R19H  input  1  downstream (z-buffer) consumes head when high with valid.
REQ-015 count_R19U  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push SHALL occur on a rising edge iff hit_valid_R18H=1 and halt_R18L=1; pushed entry stores hit and colour unmodified.
REQ-017 Pop SHALL occur iff frag_valid_R19H=1 and frag_ready_R19H=1.
REQ-018 halt_R18L SHALL be derived only from registered occupancy: 0 iff count_R19U==DEPTH; no combinational path from frag_ready_R19H.
REQ-019 Full with simultaneous push attempt and pop: pop proceeds, push not accepted, count decrements by 1.
REQ-020 Non-full, non-empty with simultaneous push and pop: both occur, count unchanged, order preserved.
REQ-021 Empty with push: no bypass; fragment appears on frag_R19S with frag_valid_R19H=1 exactly one cycle after the push edge.
REQ-022 frag_valid_R19H SHALL equal (count_R19U!=0); frag_R19S/color_R19U SHALL hold head entry stable while valid and not popped.
REQ-023 Pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; full/empty disambiguated by count.
REQ-024 hit_valid_R18H=0 SHALL never modify storage; data inputs are don't-care.
REQ-025 Output data while frag_valid_R19H=0 is don't-care for checking; implementation drives last-read or zero.
REQ-026 Strict FIFO order; no fragment dropped, duplicated or reordered.

Reset
REQ-027 rst high SHALL immediately clear pointers and count: count_R19U=0, frag_valid_R19H=0, halt_R18L=1.
REQ-028 Reset mid-operation SHALL discard all stored fragments; storage contents need not be cleared.
REQ-029 First push accepted on first rising edge after rst deasserts.

Configuration
REQ-030 With FRAG_BUF_STATS_EN defined: outputs hit_total_R19U (32b, accepted pushes) and stall_cyc_R19U (32b, cycles with hit_valid_R18H=1 and halt_R18L=0), both reset to 0, wrap at 2^32.
REQ-031 Without FRAG_BUF_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Push one fragment (x=0x000400,y=0x000800,z=0x000100), frag_ready=1 -> frag_valid high next cycle with same values, count 1 then 0.
REQ-033 frag_ready=0, push 4 fragments on consecutive cycles -> count=4, halt_R18L=0 after 4th edge; 5th held fragment not stored until a pop.
REQ-034 Full, hold valid, frag_ready=1 one cycle -> count 4->3, halt_R18L=1; next cycle push accepted, count 4; output order 1,2,3,4,5.
REQ-035 Count=2, push and pop same cycle for 10 cycles with incrementing x -> count stays 2, outputs in order, pointers wrap twice.
REQ-036 Count=3, assert rst asynchronously mid-cycle -> frag_valid=0, count=0, halt_R18L=1 before next edge; post-reset push emerges alone.
REQ-037 FRAG_BUF_STATS_EN: 6 pushes with 2 blocked cycles while full -> hit_total_R19U=6, stall_cyc_R19U=2.
